// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clock cycles per bit, rounded to nearest so both ends agree on the bit period.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: pulses bit_done once every CLKS_PER_BIT enabled cycles.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Count cycles within the current bit; wrap at the end of each bit period.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    // Pure decode of registered state: no path from inputs other than enable.
    assign bit_done = enable && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, serial frame out on o_tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i_data_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BCW          = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [BCW-1:0]       bit_cnt;
    logic                 parity_bit;
    logic                 bit_done;
    logic                 last_stop;
    logic                 accept;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .n_rst   (n_rst),
        .enable  (state != ST_IDLE),
        .clear   (state == ST_IDLE),
        .bit_done(bit_done)
    );

    // NOTE: o_ready decodes registered state only, so accept never loops back through the handshake.
    assign last_stop = (state == ST_STOP) && bit_done && (bit_cnt == LAST_STOP);
    assign o_ready   = (state == ST_IDLE) || last_stop;
    assign o_busy    = (state != ST_IDLE);
    assign accept    = i_data_valid && o_ready;

    // Frame sequencer: walks start, data, parity, stop and drives the registered line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            o_tx       <= 1'b1;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg  <= i_data;
                        parity_bit <= (PARITY == PARITY_EVEN) ? ^i_data : ~^i_data;
                        bit_cnt    <= '0;
                        o_tx       <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        o_tx      <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                o_tx  <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + BCW'(1);
                            o_tx      <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        o_tx  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            if (accept) begin
                                // Next byte starts with no idle gap.
                                shift_reg  <= i_data;
                                parity_bit <= (PARITY == PARITY_EVEN) ? ^i_data : ~^i_data;
                                o_tx       <= 1'b0;
                                state      <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    o_tx  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
